// File: rtl/wb_mem_arbiter_pkg.sv
// rtl/wb_mem_arbiter_pkg.sv - shared cache package: arbiter state type, line widths, dcache<->mem bundles
package wb_mem_arbiter_pkg;

  localparam int DC_ADDR_W = 32;
  localparam int DC_LINE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } type_memarb_state_e;

  typedef struct packed {
    logic                 req;
    logic                 wr;
    logic [DC_ADDR_W-1:0] addr;
    logic [DC_LINE_W-1:0] wdata;
    logic                 kill;
  } type_dcache2mem_s;

  typedef struct packed {
    logic                 ack;
    logic [DC_LINE_W-1:0] rdata;
  } type_mem2dcache_s;

  // Bundle the flat dcache-side ports for tops that route struct buses.
  function automatic type_dcache2mem_s to_dcache2mem(input logic req, input logic wr,
                                                      input logic [DC_ADDR_W-1:0] addr,
                                                      input logic [DC_LINE_W-1:0] wdata,
                                                      input logic kill);
    type_dcache2mem_s s;
    s.req   = req;
    s.wr    = wr;
    s.addr  = addr;
    s.wdata = wdata;
    s.kill  = kill;
    return s;
  endfunction

  function automatic type_mem2dcache_s to_mem2dcache(input logic ack,
                                                      input logic [DC_LINE_W-1:0] rdata);
    type_mem2dcache_s s;
    s.ack   = ack;
    s.rdata = rdata;
    return s;
  endfunction

endpackage

// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - round-robin icache/dcache arbiter for the single line-memory port
module wb_mem_arbiter
  import wb_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int LINE_W = DC_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_req_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  input  logic              icache_kill_i,
  output logic              icache_ack_o,
  output logic [LINE_W-1:0] icache_rdata_o,
  input  logic              dcache_req_i,
  input  logic              dcache_wr_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic [LINE_W-1:0] dcache_wdata_i,
  input  logic              dcache_kill_i,
  output logic              dcache_ack_o,
  output logic [LINE_W-1:0] dcache_rdata_o,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  output logic              mem_kill_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i
);

  type_memarb_state_e state_q, state_d;
  logic               last_grant_q;
  logic               grant_i, grant_d;

  always_comb begin
    state_d        = state_q;
    grant_i        = 1'b0;
    grant_d        = 1'b0;
    icache_ack_o   = 1'b0;
    icache_rdata_o = '0;
    dcache_ack_o   = 1'b0;
    dcache_rdata_o = '0;
    mem_kill_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // On a tie the side that did not win last time goes first.
        if (icache_req_i && (!dcache_req_i || last_grant_q)) begin
          grant_i = 1'b1;
          state_d = ST_GNT_I;
        end else if (dcache_req_i) begin
          grant_d = 1'b1;
          state_d = ST_GNT_D;
        end
      end
      ST_GNT_I: begin
        if (mem_ack_i) begin
          icache_ack_o   = 1'b1;
          icache_rdata_o = mem_rdata_i;
          state_d        = ST_IDLE;
        end else if (icache_kill_i) begin
          mem_kill_o = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_GNT_D: begin
        if (mem_ack_i) begin
          dcache_ack_o   = 1'b1;
          dcache_rdata_o = mem_rdata_i;
          state_d        = ST_IDLE;
        end else if (dcache_kill_i) begin
          mem_kill_o = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      mem_req_o    <= 1'b0;
      mem_wr_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_i) begin
        last_grant_q <= 1'b0;
        mem_req_o    <= 1'b1;
        mem_wr_o     <= 1'b0;
        mem_addr_o   <= icache_addr_i;
        mem_wdata_o  <= '0;
      end else if (grant_d) begin
        last_grant_q <= 1'b1;
        mem_req_o    <= 1'b1;
        mem_wr_o     <= dcache_wr_i;
        mem_addr_o   <= dcache_addr_i;
        mem_wdata_o  <= dcache_wdata_i;
      end else if (state_d == ST_IDLE) begin
        mem_req_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - directed self-checking bench for wb_mem_arbiter
module tb_wb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         icache_req, icache_kill, icache_ack;
  logic [31:0]  icache_addr;
  logic [127:0] icache_rdata;
  logic         dcache_req, dcache_wr, dcache_kill, dcache_ack;
  logic [31:0]  dcache_addr;
  logic [127:0] dcache_wdata, dcache_rdata;
  logic         mem_req, mem_wr, mem_kill, mem_ack;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] WB_DATA = {16{8'hA5}};
  localparam logic [127:0] RD_A    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] RD_B    = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  always #5 clk = ~clk;

  wb_mem_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icache_req_i  (icache_req),
    .icache_addr_i (icache_addr),
    .icache_kill_i (icache_kill),
    .icache_ack_o  (icache_ack),
    .icache_rdata_o(icache_rdata),
    .dcache_req_i  (dcache_req),
    .dcache_wr_i   (dcache_wr),
    .dcache_addr_i (dcache_addr),
    .dcache_wdata_i(dcache_wdata),
    .dcache_kill_i (dcache_kill),
    .dcache_ack_o  (dcache_ack),
    .dcache_rdata_o(dcache_rdata),
    .mem_req_o     (mem_req),
    .mem_wr_o      (mem_wr),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_kill_o    (mem_kill),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    icache_req = 0; icache_addr = '0; icache_kill = 0;
    dcache_req = 0; dcache_wr = 0; dcache_addr = '0; dcache_wdata = '0; dcache_kill = 0;
    mem_ack = 0; mem_rdata = '0;

    mid();
    check("rst_mem_req",   mem_req,   0);
    check("rst_mem_wr",    mem_wr,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_kill",  mem_kill,  0);
    check("rst_acks",      {icache_ack, dcache_ack}, 0);
    apply_reset();

    // dcache writeback
    dcache_req = 1; dcache_wr = 1; dcache_addr = 32'h0000_1A40; dcache_wdata = WB_DATA;
    mid();
    check("wb_not_yet", mem_req, 0);
    tick(); mid();
    check("wb_req",   mem_req,   1);
    check("wb_wr",    mem_wr,    1);
    check("wb_addr",  mem_addr,  32'h0000_1A40);
    check("wb_wdata", mem_wdata, WB_DATA);
    tick(); mid();
    tick(); mid();
    check("wb_hold_req", mem_req, 1);
    check("wb_no_ack",   dcache_ack, 0);
    tick(); mem_ack = 1; mem_rdata = RD_A; mid();
    check("wb_dack",   dcache_ack,   1);
    check("wb_iack",   icache_ack,   0);
    check("wb_irdata", icache_rdata, 0);
    tick(); mem_ack = 0; mem_rdata = '0; dcache_req = 0; dcache_wr = 0; mid();
    check("wb_req_drop", mem_req,    0);
    check("wb_dack_one", dcache_ack, 0);

    // simultaneous requests out of reset
    apply_reset();
    icache_req = 1; icache_addr = 32'h100;
    dcache_req = 1; dcache_addr = 32'h200; dcache_wr = 0;
    mid();
    tick(); mid();
    check("tie_addr_i", mem_addr, 32'h100);
    check("tie_wr_i",   mem_wr,   0);
    tick(); mem_ack = 1; mem_rdata = RD_B; mid();
    check("tie_iack",   icache_ack,   1);
    check("tie_irdata", icache_rdata, RD_B);
    check("tie_dack",   dcache_ack,   0);
    tick(); mem_ack = 0; mem_rdata = '0; icache_req = 0; mid();
    check("tie_dead", mem_req, 0);
    tick(); mid();
    check("tie_req_d",  mem_req,  1);
    check("tie_addr_d", mem_addr, 32'h200);
    tick(); mem_ack = 1; mem_rdata = RD_A; mid();
    check("tie_dack2",   dcache_ack,   1);
    check("tie_drdata2", dcache_rdata, RD_A);
    tick(); mem_ack = 0; mem_rdata = '0; dcache_req = 0; mid();

    // both held: I, D, I, D, I, D with one dead cycle
    icache_addr = 32'h300; dcache_addr = 32'h400;
    tick(); icache_req = 1; dcache_req = 1; mid();
    for (int k = 0; k < 6; k++) begin
      tick(); mid();
      check($sformatf("rr_req_%0d", k),  mem_req,  1);
      check($sformatf("rr_addr_%0d", k), mem_addr, (k % 2 == 0) ? 32'h300 : 32'h400);
      tick(); mem_ack = 1; mem_rdata = RD_B; mid();
      check($sformatf("rr_acks_%0d", k), {icache_ack, dcache_ack},
            (k % 2 == 0) ? 2'b10 : 2'b01);
      tick(); mem_ack = 0; mem_rdata = '0;
      if (k == 5) begin
        icache_req = 0; dcache_req = 0;
      end
      mid();
      check($sformatf("rr_dead_%0d", k), mem_req, 0);
    end

    // kill by owner with dcache pending
    tick(); icache_req = 1; icache_addr = 32'h500;
    dcache_req = 1; dcache_addr = 32'h600; dcache_wr = 1; dcache_wdata = WB_DATA;
    mid();
    tick(); mid();
    check("kill_gnt_addr", mem_addr, 32'h500);
    tick(); icache_kill = 1; mid();
    check("kill_pulse", mem_kill,   1);
    check("kill_noack", icache_ack, 0);
    tick(); icache_kill = 0; icache_req = 0; mid();
    check("kill_req_drop", mem_req,  0);
    check("kill_idle_mk",  mem_kill, 0);
    tick(); mid();
    check("kill_pend_req",  mem_req,   1);
    check("kill_pend_addr", mem_addr,  32'h600);
    check("kill_pend_wr",   mem_wr,    1);
    tick(); icache_kill = 1; mid();
    check("kill_nonowner", mem_kill, 0);

    // kill and ack together: ack wins
    tick(); icache_kill = 0; dcache_kill = 1; mem_ack = 1; mem_rdata = RD_A; mid();
    check("ka_dack",   dcache_ack,   1);
    check("ka_mkill",  mem_kill,     0);
    check("ka_drdata", dcache_rdata, RD_A);
    tick(); dcache_kill = 0; mem_ack = 0; mem_rdata = '0; dcache_req = 0; dcache_wr = 0; mid();
    check("ka_req_drop", mem_req, 0);

    // stray ack and kill in IDLE
    tick(); mem_ack = 1; mem_rdata = RD_B; dcache_kill = 1; mid();
    check("idle_acks",   {icache_ack, dcache_ack}, 0);
    check("idle_rdata",  icache_rdata | dcache_rdata, 0);
    check("idle_mkill",  mem_kill, 0);
    tick(); mem_ack = 0; mem_rdata = '0; dcache_kill = 0; mid();
    check("idle_stay", mem_req, 0);

    // reset mid GNT_D, then tie goes to icache
    tick(); dcache_req = 1; dcache_addr = 32'h700; mid();
    tick(); mid();
    check("rstg_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstg_async_req",  mem_req,  0);
    check("rstg_async_addr", mem_addr, 0);
    check("rstg_mkill",      mem_kill, 0);
    tick(); rst_n = 1'b1; icache_req = 1; icache_addr = 32'h800; mid();
    check("rstg_idle", mem_req, 0);
    tick(); mid();
    check("rstg_tie_addr", mem_addr, 32'h800);
    tick(); mem_ack = 1; mem_rdata = RD_B; mid();
    check("rstg_iack", icache_ack, 1);
    tick(); mem_ack = 0; mem_rdata = '0; icache_req = 0; dcache_req = 0; mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Two-requester arbiter sharing the single data-memory port between the instruction cache and the write-back data cache (including its victim-cache writebacks). It sits between both caches' memory-side interfaces and the memory/bus bridge. It grants one outstanding line transaction at a time, with round-robin fairness. It forwards kill requests and routes the memory acknowledge and read data back to the owning cache.

## Interface
- ADDR_W, 32, line address width
- LINE_W, 128, cache line data width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- icache_req_i  in  1  icache line-read request, level, held until ack
- icache_addr_i  in  ADDR_W  icache line address
- icache_kill_i  in  1  icache aborts its outstanding request
- icache_ack_o  out  1  one-cycle completion to icache
- icache_rdata_o  out  LINE_W  line data, valid when icache_ack_o
- dcache_req_i  in  1  dcache request, level, held until ack
- dcache_wr_i  in  1  1 = line writeback, 0 = line fill
- dcache_addr_i  in  ADDR_W  dcache line address
- dcache_wdata_i  in  LINE_W  writeback data
- dcache_kill_i  in  1  dcache aborts its outstanding request
- dcache_ack_o  out  1  one-cycle completion to dcache
- dcache_rdata_o  out  LINE_W  line data, valid when dcache_ack_o
- mem_req_o  out  1  request to memory, registered
- mem_wr_o  out  1  write enable to memory, registered
- mem_addr_o  out  ADDR_W  registered address
- mem_wdata_o  out  LINE_W  registered write data
- mem_kill_o  out  1  one-cycle abort to memory
- mem_ack_i  in  1  one-cycle memory completion
- mem_rdata_i  in  LINE_W  read data, valid with mem_ack_i

## Operation
- FSM states: IDLE, GNT_I, GNT_D. Register last_grant (0 = icache, 1 = dcache).
- IDLE: only icache_req_i → GNT_I; only dcache_req_i → GNT_D; both → grant the side not equal to last_grant. On entry, latch the winner's addr/wr/wdata into the mem_* registers, set mem_req_o = 1, and update last_grant.
- Icache grant: mem_wr_o = 0 and mem_wdata_o = 0.
- GNT_x: mem_req_o is held with constant addr, wr and wdata. Requests from the non-owner are ignored and held pending.
- mem_ack_i in GNT_x: combinationally drive x_ack_o = 1 and x_rdata_o = mem_rdata_i. The other side's ack_o stays 0. Next edge: mem_req_o = 0, go to IDLE.
- x_kill_i in GNT_x without mem_ack_i: combinationally drive mem_kill_o = 1. Next edge: mem_req_o = 0, go to IDLE, no ack to x.
- Kill and mem_ack_i in the same cycle: the ack wins. Deliver it normally with mem_kill_o = 0.
- Kill from the non-owner, or in IDLE: ignored. mem_kill_o = 0.
- mem_ack_i in IDLE: ignored (protocol error), no ack forwarded.
- rdata outputs are zero whenever the corresponding ack_o = 0.

## Timing
- Reset values: state IDLE, last_grant = 1 (first tie goes to icache), mem_req_o/mem_wr_o = 0, mem_addr_o/mem_wdata_o = 0. All combinational outputs read 0 in reset.
- Request latency: x_req_i sampled high in IDLE at edge N gives mem_req_o = 1 in cycle N+1.
- Ack latency: zero cycles, memory to cache.
- Back-to-back: ack in cycle M, IDLE in M+1, next mem_req_o earliest in M+2. There is one dead cycle between transactions.
- Fairness: with both requesting continuously, grants alternate I, D, I, D. Neither side waits more than one full transaction.
- Reset asserted mid-transaction: immediate return to IDLE with mem_req_o = 0. No kill is issued; memory is reset by the same rst_n.

## Structure
- The shared cache package owns:
  - the state enum type_memarb_state_e
  - ADDR_W and LINE_W defaults, aligned with the dcache line width constants
  - the flat-port ↔ type_dcache2mem_s / type_mem2dcache_s mapping, used by the instantiating top
- No sub-module. A single file holds the FSM, grant register and output muxes.

## Test plan
- Single dcache writeback, addr 0x0000_1A40, wdata all-0xA5. Expected: mem_req_o/mem_wr_o = 1 one cycle later. mem_ack_i after 3 cycles gives dcache_ack_o = 1 for one cycle and icache_ack_o = 0.
- Simultaneous requests out of reset, icache 0x100 and dcache 0x200. Expected: icache granted first (mem_addr_o = 0x100), then dcache (0x200) two cycles after the icache ack.
- Both requesters held high for 6 transactions. Expected grant order I, D, I, D, I, D, with exactly one idle cycle between each mem_req_o deassert and reassert.
- Kill: icache granted, icache_kill_i pulsed in cycle 2. Expected: mem_kill_o = 1 that cycle, mem_req_o = 0 next cycle, no icache_ack_o. A pending dcache request is granted the cycle after IDLE.
- Kill and mem_ack_i in the same cycle for dcache. Expected: dcache_ack_o = 1, mem_kill_o = 0, rdata forwarded unchanged.
- rst_n dropped while in GNT_D. Expected: mem_req_o = 0 asynchronously. After release, the FSM is IDLE and the first tie goes to icache.
